// File: rtl/memp_access_sequencer.sv
// P-vector memory controller: streams a wrapping address range out over valid/ready
// and round-robin arbitrates the single memory write port between two writers.
module memp_access_sequencer #(
    parameter int ELEMENT_WIDTH = 64,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDRESS_WIDTH = 20,
    parameter int DEPTH         = 1001
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [ADDRESS_WIDTH-1:0]               base_address,
    input  logic [ADDRESS_WIDTH-1:0]               num_rows,
    output logic [ADDRESS_WIDTH-1:0]               read_address,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   mem_data,
    output logic                                   rd_valid,
    input  logic                                   rd_ready,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   rd_data,
    input  logic                                   wr_req_a,
    input  logic [ADDRESS_WIDTH-1:0]               wr_addr_a,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   wr_data_a,
    output logic                                   wr_gnt_a,
    input  logic                                   wr_req_b,
    input  logic [ADDRESS_WIDTH-1:0]               wr_addr_b,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   wr_data_b,
    output logic                                   wr_gnt_b,
    output logic                                   write_enable,
    output logic [ADDRESS_WIDTH-1:0]               write_address,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   write_data,
    output logic                                   wr_drop,
    output logic                                   busy,
    output logic                                   finish
);
    localparam int W  = NO_OF_UNITS * ELEMENT_WIDTH;
    localparam int AW = ADDRESS_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr, remaining;
    logic          load, drained;
    logic          prefer_b, granted;
    logic [AW-1:0] sel_addr;
    logic [W-1:0]  sel_data;

    function automatic logic [AW-1:0] wrap_base(input logic [AW-1:0] a);
        return a % DEPTH_A;
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + AW'(1);
    endfunction

    // The output register refills whenever it is empty or its beat is leaving this edge.
    assign load    = (state == READ) && (remaining != '0) && (!rd_valid || rd_ready);
    assign drained = (remaining == '0) && (!rd_valid || rd_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (num_rows != '0) ? READ : DONE;
            READ: if (drained) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        finish       = (state == DONE);
        read_address = (state == READ) ? ptr : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            remaining <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else if (state == IDLE && start) begin
            ptr       <= wrap_base(base_address);
            remaining <= num_rows;
        end else if (load) begin
            rd_data   <= mem_data;
            rd_valid  <= 1'b1;
            ptr       <= next_addr(ptr);
            remaining <= remaining - AW'(1);
        end else if (rd_valid && rd_ready) begin
            rd_valid  <= 1'b0;
        end
    end

    // Round-robin: on contention the side not served last wins; pointer moves only on a grant.
    always_comb begin
        wr_gnt_a = wr_req_a && (!wr_req_b || !prefer_b);
        wr_gnt_b = wr_req_b && (!wr_req_a || prefer_b);
        granted  = wr_gnt_a || wr_gnt_b;
        sel_addr = wr_gnt_b ? wr_addr_b : wr_addr_a;
        sel_data = wr_gnt_b ? wr_data_b : wr_data_a;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefer_b      <= 1'b0;
            write_enable  <= 1'b0;
            wr_drop       <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
        end else begin
            if (wr_gnt_a)      prefer_b <= 1'b1;
            else if (wr_gnt_b) prefer_b <= 1'b0;
            write_enable <= granted && (sel_addr < DEPTH_A);
            wr_drop      <= granted && (sel_addr >= DEPTH_A);
            if (granted) begin
                write_address <= sel_addr;
                write_data    <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_memp_access_sequencer.sv
// Bench for memp_access_sequencer: behavioural memory plus a reference copy of its
// contents, checking sweeps, stalls, arbitration, dropped writes and mid-sweep reset.
module tb_memp_access_sequencer;
    localparam int AW    = 20;
    localparam int W     = 512;
    localparam int DEPTH = 1001;

    logic          clk = 1'b0;
    logic          reset, start, rd_ready;
    logic [AW-1:0] base_address, num_rows, read_address;
    logic [W-1:0]  mem_data, rd_data;
    logic          rd_valid;
    logic          wr_req_a, wr_req_b, wr_gnt_a, wr_gnt_b;
    logic [AW-1:0] wr_addr_a, wr_addr_b, write_address;
    logic [W-1:0]  wr_data_a, wr_data_b, write_data;
    logic          write_enable, wr_drop, busy, finish;

    logic [W-1:0]  mem      [DEPTH];
    logic [W-1:0]  seed_mem [DEPTH];
    logic [W-1:0]  ref_mem  [DEPTH];
    logic          seed_en;
    int            n_total = 0, n_pass = 0, n_fail = 0;
    int            last_side;   // 0: A granted last, 1: B granted last, 2: none since reset

    always #5 clk = ~clk;

    memp_access_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .base_address(base_address),
        .num_rows(num_rows), .read_address(read_address), .mem_data(mem_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .wr_req_a(wr_req_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a), .wr_gnt_a(wr_gnt_a),
        .wr_req_b(wr_req_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b), .wr_gnt_b(wr_gnt_b),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .wr_drop(wr_drop), .busy(busy), .finish(finish)
    );

    assign mem_data = (read_address < AW'(DEPTH)) ? mem[read_address] : '0;

    always @(posedge clk) begin
        if (seed_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed_mem[i];
        end else if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_read_address"}, read_address, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finish"}, finish, 0);
        chk({tag, "_write_enable"}, write_enable, 0);
        chk({tag, "_write_address"}, write_address, 0);
        chk({tag, "_write_data"}, write_data, 0);
        chk({tag, "_wr_drop"}, wr_drop, 0);
    endtask

    // mode 0: always ready; 1: ready 1,0,0 repeating; 2: always ready plus a stray start; 3: random ready
    task automatic sweep(input int base, input int num, input int mode, input string tag);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] prev;
        logic         prev_stall;
        int           nb, nfin, last_cyc, fin_cyc;
        for (int i = 0; i < num; i++) exp_q.push_back(ref_mem[((base % DEPTH) + i) % DEPTH]);
        start = 1'b1;
        base_address = AW'(base);
        num_rows = AW'(num);
        step();
        start = 1'b0;
        nb = 0; nfin = 0; last_cyc = -10; fin_cyc = -1; prev_stall = 1'b0; prev = '0;
        for (int cyc = 0; cyc < 4 * num + 40 && nfin == 0; cyc++) begin
            case (mode)
                1:       rd_ready = ((cyc % 3) == 0);
                3:       rd_ready = $urandom_range(0, 1) == 1;
                default: rd_ready = 1'b1;
            endcase
            if (mode == 2 && cyc == 2) begin
                start = 1'b1; base_address = AW'(500); num_rows = AW'(2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (prev_stall) chk({tag, "_stall_hold"}, rd_data, prev);
            if (finish) begin
                nfin++;
                fin_cyc = cyc;
                chk({tag, "_rd_valid_at_finish"}, rd_valid, 0);
            end
            if (rd_valid && rd_ready) begin
                if (nb < num) chk($sformatf("%s_beat%0d", tag, nb), rd_data, exp_q[nb]);
                nb++;
                last_cyc = cyc;
            end
            prev_stall = rd_valid && !rd_ready;
            prev = rd_data;
            step();
        end
        start = 1'b0;
        chk({tag, "_beat_count"}, nb, num);
        chk({tag, "_finish_count"}, nfin, 1);
        chk({tag, "_finish_latency"}, fin_cyc, last_cyc + 1);
        chk({tag, "_finish_after"}, finish, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic arb_step(input logic ra, input logic rb, input int aa, input int ab, input string tag);
        logic [W-1:0] da, db, exp_d;
        logic         ea, eb;
        int           exp_a;
        da = rand_word();
        db = rand_word();
        wr_req_a = ra; wr_addr_a = AW'(aa); wr_data_a = da;
        wr_req_b = rb; wr_addr_b = AW'(ab); wr_data_b = db;
        ea = ra && (!rb || last_side != 0);
        eb = rb && (!ra || last_side == 0);
        #1;
        chk({tag, "_gnt_a"}, wr_gnt_a, ea);
        chk({tag, "_gnt_b"}, wr_gnt_b, eb);
        step();
        wr_req_a = 1'b0;
        wr_req_b = 1'b0;
        exp_a = ea ? aa : ab;
        exp_d = ea ? da : db;
        chk({tag, "_write_enable"}, write_enable, (ea || eb) && exp_a < DEPTH);
        chk({tag, "_wr_drop"}, wr_drop, (ea || eb) && exp_a >= DEPTH);
        if (ea || eb) begin
            last_side = ea ? 0 : 1;
            chk({tag, "_write_address"}, write_address, exp_a);
            if (exp_a < DEPTH) begin
                chk({tag, "_write_data"}, write_data, exp_d);
                ref_mem[exp_a] = exp_d;
            end
        end
    endtask

    initial begin
        int nb;
        reset = 1'b1; seed_en = 1'b1; start = 1'b0; rd_ready = 1'b0;
        base_address = '0; num_rows = '0;
        wr_req_a = 1'b0; wr_req_b = 1'b0; wr_addr_a = '0; wr_addr_b = '0;
        wr_data_a = '0; wr_data_b = '0;
        last_side = 2;
        for (int i = 0; i < DEPTH; i++) begin
            seed_mem[i] = rand_word();
            ref_mem[i] = seed_mem[i];
        end
        step();
        step();
        seed_en = 1'b0;
        chk_quiet("reset");
        chk("reset_gnt_a", wr_gnt_a, 0);
        reset = 1'b0;
        step();

        sweep(0, 4, 0, "t1");
        sweep(998, 5, 0, "t2_wrap");
        sweep(1500, 3, 0, "t2_base_mod");
        sweep(20, 8, 1, "t3_stall");

        arb_step(1, 1, 10, 20, "t4_c0");
        arb_step(1, 1, 10, 20, "t4_c1");
        arb_step(1, 1, 10, 20, "t4_c2");
        arb_step(1, 1, 10, 20, "t4_c3");
        arb_step(1, 0, 1001, 0, "t4_drop");
        step();
        sweep(8, 16, 0, "t4_readback");

        start = 1'b1; base_address = AW'(7); num_rows = '0;
        step();
        start = 1'b0;
        chk("t5_zero_finish", finish, 1);
        chk("t5_zero_busy", busy, 1);
        chk("t5_zero_rd_valid", rd_valid, 0);
        step();
        chk("t5_zero_finish_after", finish, 0);
        chk("t5_zero_busy_after", busy, 0);
        sweep(0, 4, 2, "t5_start_busy");

        for (int i = 0; i < 40; i++)
            arb_step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1010), $urandom_range(0, 1010), $sformatf("rarb%0d", i));
        step();
        sweep($urandom_range(0, 3000), DEPTH, 3, "full_sweep");

        start = 1'b1; base_address = '0; num_rows = AW'(10); rd_ready = 1'b1;
        step();
        start = 1'b0;
        nb = 0;
        for (int c = 0; c < 40 && nb < 3; c++) begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                chk($sformatf("t6_beat%0d", nb), rd_data, ref_mem[nb]);
                nb++;
            end
            step();
        end
        chk("t6_reached_beat3", nb, 3);
        wr_req_a = 1'b1; wr_addr_a = AW'(5); wr_data_a = rand_word();
        step();
        wr_req_a = 1'b0;
        chk("t6_write_in_flight", write_enable, 1);
        chk("t6_busy_before_reset", busy, 1);
        reset = 1'b1;
        last_side = 2;
        #1;
        chk_quiet("t6_reset");
        step();
        reset = 1'b0;
        step();
        sweep(0, 8, 0, "t6_fresh");
        arb_step(1, 1, 30, 31, "t6_arb_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
